// File: rtl/compare_pkg.sv
// Shared types and defaults for the comparator outcome tracker.
package compare_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam int CNT_W_DEF    = 8;
  localparam int LOCK_RUN_DEF = 4;
  localparam logic [3:0] RUN_MAX = 4'd15;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr and reset both return it to zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/compare_result_tracker.sv
// Counts comparator outcomes, tracks runs of equal results and locks on a
// long enough run; malformed flag sets park the block in ERR until cleared.
module compare_result_tracker
  import compare_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int LOCK_RUN = LOCK_RUN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  input  logic             clear,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [3:0]       run_len,
  output logic             locked,
  output logic             err,
  output state_t           state_dbg
);

  localparam logic [3:0] LOCK_THR = 4'(LOCK_RUN);

  state_t     state, state_next;
  logic       xfer, one_hot, good_xfer, bad_xfer;
  logic [3:0] run_inc;

  // Handshake: a result is consumed on any rising edge where in_valid and
  // in_ready are both high; in_ready never looks at in_valid or the flags.
  assign in_ready  = !clear && (state != ERR) && rst_n;
  assign xfer      = in_valid && in_ready;
  assign one_hot   = ({eq, lt, gt} == 3'b100) || ({eq, lt, gt} == 3'b010) ||
                     ({eq, lt, gt} == 3'b001);
  assign good_xfer = xfer && one_hot;
  assign bad_xfer  = xfer && !one_hot;
  assign run_inc   = (run_len == RUN_MAX) ? RUN_MAX : run_len + 4'd1;

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(good_xfer && eq), .cnt(eq_cnt)
  );
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(good_xfer && lt), .cnt(lt_cnt)
  );
  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clear), .inc(good_xfer && gt), .cnt(gt_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state   <= IDLE;
      run_len <= 4'd0;
    end else begin
      state <= state_next;
      if (good_xfer) begin
        run_len <= eq ? run_inc : 4'd0;
      end
    end
  end

  // Any good transfer lands in TRACK unless it completes a lock-length run;
  // an eq while LOCKED keeps run_len >= LOCK_THR, so LOCKED is held.
  always_comb begin
    state_next = state;
    if (bad_xfer) begin
      state_next = ERR;
    end else if (good_xfer) begin
      state_next = (eq && (run_inc >= LOCK_THR)) ? LOCKED : TRACK;
    end
  end

  assign locked    = (state == LOCKED);
  assign err       = (state == ERR);
  assign state_dbg = state;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs of an
// 8-bit and a 4-bit counter instance, plus directed checks against constants.
module tb_compare_result_tracker;
  import compare_pkg::*;

  localparam int W = 54;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, eq = 1'b0, lt = 1'b0, gt = 1'b0, clear = 1'b0;

  logic [7:0] d8_eq, d8_lt, d8_gt;
  logic [3:0] d4_eq, d4_lt, d4_gt;
  logic [3:0] d8_run, d4_run;
  logic       d8_lk, d4_lk, d8_er, d4_er, d8_rdy, d4_rdy;
  logic [1:0] d8_st, d4_st;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int     m_eq, m_lt, m_gt, m_run;
  state_t m_st;

  always #5 clk = ~clk;

  compare_result_tracker #(.CNT_W(8), .LOCK_RUN(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d8_rdy),
    .eq(eq), .lt(lt), .gt(gt), .clear(clear),
    .eq_cnt(d8_eq), .lt_cnt(d8_lt), .gt_cnt(d8_gt), .run_len(d8_run),
    .locked(d8_lk), .err(d8_er), .state_dbg(d8_st)
  );

  compare_result_tracker #(.CNT_W(4), .LOCK_RUN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_rdy),
    .eq(eq), .lt(lt), .gt(gt), .clear(clear),
    .eq_cnt(d4_eq), .lt_cnt(d4_lt), .gt_cnt(d4_gt), .run_len(d4_run),
    .locked(d4_lk), .err(d4_er), .state_dbg(d4_st)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v >= max) ? max : v;
  endfunction

  function automatic logic [W-1:0] predict();
    logic [3:0] run;
    logic       lk, er, rdy;
    logic [1:0] st;
    run = 4'(m_run);
    lk  = (m_st == LOCKED);
    er  = (m_st == ERR);
    rdy = !clear && (m_st != ERR) && rst_n;
    st  = m_st;
    return {8'(sat(m_eq, 255)), 8'(sat(m_lt, 255)), 8'(sat(m_gt, 255)),
            4'(sat(m_eq, 15)), 4'(sat(m_lt, 15)), 4'(sat(m_gt, 15)),
            run, lk, er, rdy, st, run, lk, er, rdy, st};
  endfunction

  // Model update applied at each rising edge with the inputs then present.
  task automatic model_edge();
    int hot;
    hot = int'(eq) + int'(lt) + int'(gt);
    if (!rst_n || clear) begin
      m_eq = 0; m_lt = 0; m_gt = 0; m_run = 0; m_st = IDLE;
    end else if (in_valid && m_st != ERR) begin
      if (hot != 1) begin
        m_st = ERR;
      end else if (eq) begin
        m_eq++;
        if (m_run < 15) m_run++;
        m_st = (m_run >= 4) ? LOCKED : TRACK;
      end else begin
        if (lt) m_lt++;
        if (gt) m_gt++;
        m_run = 0;
        m_st = TRACK;
      end
    end
  endtask

  task automatic step(input logic v, input logic e, input logic l, input logic g,
                      input logic c);
    logic [W-1:0] exp;
    in_valid = v; eq = e; lt = l; gt = g; clear = c;
    @(posedge clk);
    model_edge();
    exp_q.push_back(predict());
    #1;
    exp = exp_q.pop_front();
    check("outputs", 64'({d8_eq, d8_lt, d8_gt, d4_eq, d4_lt, d4_gt,
                          d8_run, d8_lk, d8_er, d8_rdy, d8_st,
                          d4_run, d4_lk, d4_er, d4_rdy, d4_st}), 64'(exp));
  endtask

  task automatic cmp_step(input int a, input int b, input logic v);
    step(v, a == b, a < b, a > b, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_eq = 0; m_lt = 0; m_gt = 0; m_run = 0; m_st = IDLE;
    rst_n = 1'b0;
    repeat (3) cmp_step(5, 5, 1'b1);
    check("reset_ready", 64'(d8_rdy), 64'd0);
    check("reset_eq_cnt", 64'(d8_eq), 64'd0);
    check("reset_run", 64'(d8_run), 64'd0);
    rst_n = 1'b1;
    cmp_step(0, 0, 1'b0);
    check("ready_after_reset", 64'(d8_rdy), 64'd1);
    check("idle_after_reset", 64'(d8_st), 64'(IDLE));

    for (int i = 0; i < 4; i++) begin
      cmp_step(5, 5, 1'b1);
      check("run_len_build", 64'(d8_run), 64'(i + 1));
    end
    check("locked_after_4", 64'(d8_lk), 64'd1);
    check("eq_cnt_4", 64'(d8_eq), 64'd4);

    cmp_step(3, 9, 1'b1);
    check("lt_cnt_1", 64'(d8_lt), 64'd1);
    check("unlock_run", 64'(d8_run), 64'd0);
    check("unlock_locked", 64'(d8_lk), 64'd0);
    check("unlock_track", 64'(d8_st), 64'(TRACK));

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("err_set", 64'(d8_er), 64'd1);
    check("err_ready", 64'(d8_rdy), 64'd0);
    check("err_eq_frozen", 64'(d8_eq), 64'd4);
    cmp_step(7, 1, 1'b1);
    check("err_gt_frozen", 64'(d8_gt), 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_idle", 64'(d8_st), 64'(IDLE));
    check("clear_counts", 64'({d8_eq, d8_lt, d8_gt}), 64'd0);
    cmp_step(0, 0, 1'b0);
    check("clear_ready", 64'(d8_rdy), 64'd1);

    repeat (20) cmp_step(9, 2, 1'b1);
    check("gt_sat_4bit", 64'(d4_gt), 64'd15);
    check("gt_cnt_8bit", 64'(d8_gt), 64'd20);
    check("sat_others", 64'({d4_eq, d4_lt}), 64'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp_step(5, 5, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clear_wins_eq", 64'(d8_eq), 64'd0);
    check("clear_wins_run", 64'(d8_run), 64'd0);
    repeat (3) cmp_step(4, 4, 1'b1);
    check("run_3", 64'(d8_run), 64'd3);
    rst_n = 1'b0;
    cmp_step(4, 4, 1'b1);
    check("midrun_reset", 64'({d8_eq, d8_lt, d8_gt, d8_run, d8_lk, d8_er, d8_rdy}), 64'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        while ($urandom_range(0, 3) == 0) begin
          step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
        end
        cmp_step(a, b, 1'b1);
      end
    end
    check("sweep_eq", 64'(d8_eq), 64'd16);
    check("sweep_lt", 64'(d8_lt), 64'd120);
    check("sweep_gt", 64'(d8_gt), 64'd120);
    check("sweep_err", 64'(d8_er), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
